gate_self_test: RTL and testbench

GATE_SELF_TEST -- requirements
Module: gate_self_test

---
 rtl/gate_self_test.sv | 93 +++++++++
 tb/tb_gate_self_test.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/gate_self_test.sv
// gate_self_test: walks the four (a,b) vectors through an external gate block and checks all seven outputs.
// Optional GATE_SELF_TEST_STOP_ON_FAIL_EN: end the run at the first CHECK cycle that sees a mismatch.
module gate_self_test #(
   parameter int SETTLE_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       a_out,
   output logic       b_out,
   input  logic       and_in,
   input  logic       or_in,
   input  logic       not_in,
   input  logic       nand_in,
   input  logic       nor_in,
   input  logic       xor_in,
   input  logic       xnor_in,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [4:0] err_count,
   output logic [6:0] fail_vec
);
   typedef enum logic [2:0] {IDLE, APPLY, WAIT, CHECK, DONE} state_t;
   localparam logic [3:0] WAIT_INIT = 4'(SETTLE_CYCLES > 0 ? SETTLE_CYCLES - 1 : 0);
   state_t     state;
   logic [1:0] idx;
   logic [3:0] cnt;
   logic [6:0] mm;
   logic [4:0] err_nxt;
   logic       stop;
   always_comb begin
      mm = {xnor_in, xor_in, nor_in, nand_in, not_in, or_in, and_in} ^
           {~(a_out ^ b_out), a_out ^ b_out, ~(a_out | b_out), ~(a_out & b_out), ~a_out, a_out | b_out, a_out & b_out};
      err_nxt = err_count + 5'($countones(mm));
`ifdef GATE_SELF_TEST_STOP_ON_FAIL_EN
      stop = (idx == 2'd3) || (|mm);
`else
      stop = idx == 2'd3;
`endif
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         idx       <= '0;
         cnt       <= '0;
         a_out     <= 1'b0;
         b_out     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         err_count <= '0;
         fail_vec  <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               err_count <= '0;
               fail_vec  <= '0;
               idx       <= '0;
               pass      <= 1'b0;
               busy      <= 1'b1;
               state     <= APPLY;
            end
            APPLY: begin
               a_out <= idx[1];
               b_out <= idx[0];
               cnt   <= WAIT_INIT;
               state <= SETTLE_CYCLES == 0 ? CHECK : WAIT;
            end
            WAIT: if (cnt == '0) state <= CHECK;
                  else cnt <= cnt - 4'd1;
            CHECK: begin
               fail_vec  <= fail_vec | mm;
               err_count <= err_nxt;
               if (stop) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  pass  <= err_nxt == '0;
                  state <= DONE;
               end else begin
                  idx   <= idx + 2'd1;
                  state <= APPLY;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_gate_self_test.sv
// tb_gate_self_test: directed checks of gate_self_test with a faultable gate model.
module tb_gate_self_test;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0, start0 = 1'b0;
   int   fault = 0;
   int   checks = 0, errors = 0;
   logic a_out, b_out, busy, done, pass;
   logic [4:0] err_count;
   logic [6:0] fail_vec;
   logic a0, b0, busy0, done0, pass0;
   logic [4:0] err0;
   logic [6:0] fail0;
   always #5 clk = ~clk;

   // fault 1: xor stuck at 0, fault 2: nand behaves as and
   wire g_and  = a_out & b_out;
   wire g_or   = a_out | b_out;
   wire g_not  = ~a_out;
   wire g_nand = fault == 2 ? (a_out & b_out) : ~(a_out & b_out);
   wire g_nor  = ~(a_out | b_out);
   wire g_xor  = fault == 1 ? 1'b0 : (a_out ^ b_out);
   wire g_xnor = ~(a_out ^ b_out);

   gate_self_test #(.SETTLE_CYCLES(1)) dut (
      .clk(clk), .rst(rst), .start(start), .a_out(a_out), .b_out(b_out),
      .and_in(g_and), .or_in(g_or), .not_in(g_not), .nand_in(g_nand),
      .nor_in(g_nor), .xor_in(g_xor), .xnor_in(g_xnor),
      .busy(busy), .done(done), .pass(pass), .err_count(err_count), .fail_vec(fail_vec)
   );

   gate_self_test #(.SETTLE_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst), .start(start0), .a_out(a0), .b_out(b0),
      .and_in(a0 & b0), .or_in(a0 | b0), .not_in(~a0), .nand_in(~(a0 & b0)),
      .nor_in(~(a0 | b0)), .xor_in(a0 ^ b0), .xnor_in(~(a0 ^ b0)),
      .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .fail_vec(fail0)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run(output int lat);
      start = 1'b1;
      tick();
      chk("busy_on_accept", busy, 1);
      start = 1'b0;
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!done && lat < 100);
   endtask

   task automatic check_result(input string tag, input int lat, input int exp_lat,
                               input logic exp_pass, input logic [4:0] exp_err, input logic [6:0] exp_fail);
      chk({tag, "_latency"}, lat, exp_lat);
      chk({tag, "_busy_at_done"}, busy, 0);
      chk({tag, "_pass"}, pass, exp_pass);
      chk({tag, "_err_count"}, err_count, exp_err);
      chk({tag, "_fail_vec"}, fail_vec, exp_fail);
      tick();
      chk({tag, "_done_pulse_end"}, done, 0);
      chk({tag, "_idle_holds_err"}, err_count, exp_err);
   endtask

   initial begin
      int lat;
      int seen;
      repeat (3) tick();
      chk("rst_a", a_out, 0);
      chk("rst_b", b_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass, 0);
      chk("rst_err", err_count, 0);
      chk("rst_fail", fail_vec, 0);
      chk("rst_busy0", busy0, 0);
      rst = 1'b0;
      tick();

      fault = 0;
      run(lat);
      check_result("ideal", lat, 12, 1'b1, 5'd0, 7'd0);
      chk("ideal_last_vec", {a_out, b_out}, 2'b11);
      chk("ideal_idle_pass", pass, 1);

      fault = 1;
      run(lat);
`ifdef GATE_SELF_TEST_STOP_ON_FAIL_EN
      check_result("xor_stuck", lat, 6, 1'b0, 5'd1, 7'b0100000);
`else
      check_result("xor_stuck", lat, 12, 1'b0, 5'd2, 7'b0100000);
`endif

      fault = 2;
      run(lat);
`ifdef GATE_SELF_TEST_STOP_ON_FAIL_EN
      check_result("nand_as_and", lat, 3, 1'b0, 5'd1, 7'b0001000);
`else
      check_result("nand_as_and", lat, 12, 1'b0, 5'd4, 7'b0001000);
`endif

      // abort during WAIT of vector 2 with errors already counted
      fault = 2;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (7) tick();
`ifndef GATE_SELF_TEST_STOP_ON_FAIL_EN
      chk("mid_vec2", {a_out, b_out}, 2'b10);
      chk("mid_err", err_count, 2);
`endif
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_zero_outs", {a_out, b_out, busy, done, pass}, 0);
      chk("abort_err", err_count, 0);
      chk("abort_fail", fail_vec, 0);
      seen = 0;
      repeat (15) begin
         tick();
         if (done) seen++;
      end
      chk("abort_no_done", seen, 0);
      fault = 0;
      run(lat);
      check_result("recover", lat, 12, 1'b1, 5'd0, 7'd0);

      // SETTLE_CYCLES=0 instance with start held high
      start0 = 1'b1;
      tick();
      chk("s0_accept_busy", busy0, 1);
      repeat (7) tick();
      chk("s0_no_early_done", done0, 0);
      tick();
      chk("s0_done", done0, 1);
      chk("s0_busy_at_done", busy0, 0);
      chk("s0_pass", pass0, 1);
      tick();
      chk("s0_done_cycle_ignores_start", {busy0, done0}, 2'b00);
      tick();
      chk("s0_second_accept", busy0, 1);
      repeat (20) tick();
      start0 = 1'b0;
      repeat (12) tick();
      chk("s0_idle_after", busy0, 0);
      chk("s0_err", err0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
